// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Turns one field-level instruction request per handshake into 32-bit MIPS
// machine words on a valid/ready output stream. This is the inverse of the
// decode-stage opcode classification. The pseudo-instructions li, move, b and
// bnez are expanded into real R/I-type words. li can take two words (lui then
// ori). While the second word is pending, the input side is stalled.
//
// Parameters:
//   LI_OPT     1: li emits a single word when either immediate half is zero
//              0: li always emits lui+ori
//
// Ports:
//   clock      system clock, all state updates on posedge
//   reset      asynchronous active-high reset
//   in_valid   request present
//   in_ready   request accepted on posedge when in_valid & in_ready
//   in_kind    0=R 1=I 2=J 3=LI 4=MOVE 5=B 6=BNEZ 7=illegal
//   in_opcode  opcode for I and J kinds
//   in_rs      rs field (source register for MOVE/BNEZ)
//   in_rt      rt field (destination register for LI)
//   in_rd      rd field (destination register for MOVE)
//   in_shamt   shamt for R kind
//   in_funct   funct for R kind
//   in_imm     immediate; LI uses all 32 bits, I/B/BNEZ use [15:0]
//   in_target  J-kind target
//   out_valid  out_instr holds a word
//   out_ready  consumer takes the word on posedge when out_valid & out_ready
//   out_instr  encoded word
//   out_last   word is the final word of its request
//   err        one-cycle pulse after an illegal request was accepted
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter bit LI_OPT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  localparam logic [2:0] K_R    = 3'd0;
  localparam logic [2:0] K_I    = 3'd1;
  localparam logic [2:0] K_J    = 3'd2;
  localparam logic [2:0] K_LI   = 3'd3;
  localparam logic [2:0] K_MOVE = 3'd4;
  localparam logic [2:0] K_B    = 3'd5;
  localparam logic [2:0] K_BNEZ = 3'd6;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] FN_ADDU    = 6'h21;

  logic [0:0]  r_state;
  logic [31:0] r_pending;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic        r_out_last;
  logic        r_err;

  logic        w_handoff;
  logic        w_accept;
  logic        w_in_ready;
  logic [15:0] w_hi;
  logic [15:0] w_lo;
  logic [31:0] w_word;
  logic        w_last;
  logic        w_two;
  logic [31:0] w_pend;
  logic        w_illegal;

  assign w_hi       = in_imm[31:16];
  assign w_lo       = in_imm[15:0];
  assign w_handoff  = r_out_valid & out_ready;
  // Only combinational input-to-output path: in_ready follows out_ready.
  assign w_in_ready = (r_state == ST_IDLE) & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_last  = r_out_last;
  assign err       = r_err;

  // Decode the incoming request into its first word and an optional pending second word.
  always_comb begin
    w_word    = 32'h0000_0000;
    w_last    = 1'b1;
    w_two     = 1'b0;
    w_pend    = 32'h0000_0000;
    w_illegal = 1'b0;
    case (in_kind)
      K_R:    w_word = {OP_SPECIAL, in_rs, in_rt, in_rd, in_shamt, in_funct};
      K_I:    w_word = {in_opcode, in_rs, in_rt, w_lo};
      K_J: begin
        if ((in_opcode == OP_J) || (in_opcode == OP_JAL)) begin
          w_word = {in_opcode, in_target};
        end else begin
          w_illegal = 1'b1;
        end
      end
      K_LI: begin
        if ((LI_OPT == 1'b1) && (w_hi == 16'h0000)) begin
          // Upper half empty: ori from $zero loads the value, including imm==0.
          w_word = {OP_ORI, 5'd0, in_rt, w_lo};
        end else if ((LI_OPT == 1'b1) && (w_lo == 16'h0000)) begin
          w_word = {OP_LUI, 5'd0, in_rt, w_hi};
        end else begin
          // The second word ors the low half into the register that lui just wrote.
          w_word = {OP_LUI, 5'd0, in_rt, w_hi};
          w_last = 1'b0;
          w_two  = 1'b1;
          w_pend = {OP_ORI, in_rt, in_rt, w_lo};
        end
      end
      K_MOVE: w_word = {OP_SPECIAL, 5'd0, in_rs, in_rd, 5'd0, FN_ADDU};
      K_B:    w_word = {OP_BEQ, 5'd0, 5'd0, w_lo};
      K_BNEZ: w_word = {OP_BNE, 5'd0, in_rs, w_lo};
      default: w_illegal = 1'b1;
    endcase
  end

  // Sequence state, output word register, pending-word latch and error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pending   <= 32'h0000_0000;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0000_0000;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept & w_illegal;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_illegal) begin
            // A load in the same edge as a handoff replaces the word without a bubble.
            r_out_valid <= 1'b1;
            r_out_instr <= w_word;
            r_out_last  <= w_last;
            if (w_two) begin
              r_state   <= ST_SECOND;
              r_pending <= w_pend;
            end else begin
              r_state   <= ST_IDLE;
            end
          end else if (w_handoff) begin
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= r_out_valid;
          end
        end
        ST_SECOND: begin
          if (w_handoff) begin
            r_out_instr <= r_pending;
            r_out_last  <= 1'b1;
            r_pending   <= 32'h0000_0000;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_SECOND;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Drives instr_encoder (LI_OPT=1 as dut_a, LI_OPT=0 as dut_b) with directed
// and random requests. A reference model expands every accepted request into
// expected words, which are queued and compared at each output handoff.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clock;
  logic        reset;
  logic [2:0]  in_kind;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [31:0] in_imm;
  logic [25:0] in_target;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, err_a;
  logic [31:0] out_instr_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, err_b;
  logic [31:0] out_instr_b;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } exp_t;

  exp_t qa[$];
  logic exp_err_a;
  logic exp_ready;

  instr_encoder #(.LI_OPT(1'b1)) dut_a (
    .clock(clock), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_kind(in_kind), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_instr(out_instr_a),
    .out_last(out_last_a), .err(err_a)
  );

  instr_encoder #(.LI_OPT(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_kind(in_kind), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_instr(out_instr_b),
    .out_last(out_last_b), .err(err_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // MIPS field packing written as plain arithmetic.
  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return 32'((rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + fn);
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm16);
    return 32'((op << 26) + (rs << 21) + (rt << 16) + (imm16 % 65536));
  endfunction

  // Reference model: list of words a request expands to, and whether it is illegal.
  task automatic model(input bit opt, input int k, input int op, input int rs, input int rt,
                       input int rd, input int sh, input int fn, input logic [31:0] imm,
                       input int tgt, output int n, output logic [31:0] w0,
                       output logic [31:0] w1, output bit bad);
    int hi, lo;
    hi  = int'(imm >> 16);
    lo  = int'(imm & 32'h0000_FFFF);
    n   = 1;
    w0  = 32'h0;
    w1  = 32'h0;
    bad = 1'b0;
    case (k)
      0: w0 = rtype(rs, rt, rd, sh, fn);
      1: w0 = itype(op, rs, rt, lo);
      2: begin
        if (op == 2 || op == 3) w0 = 32'(op * 67108864 + tgt);
        else begin n = 0; bad = 1'b1; end
      end
      3: begin
        if (opt && hi == 0)      w0 = itype(13, 0, rt, lo);
        else if (opt && lo == 0) w0 = itype(15, 0, rt, hi);
        else begin
          n  = 2;
          w0 = itype(15, 0, rt, hi);
          w1 = itype(13, rt, rt, lo);
        end
      end
      4: w0 = rtype(0, rs, rd, 0, 33);
      5: w0 = itype(4, 0, 0, lo);
      6: w0 = itype(5, 0, rs, lo);
      default: begin n = 0; bad = 1'b1; end
    endcase
  endtask

  task automatic set_req(input int k, input int op, input int rs, input int rt, input int rd,
                         input int sh, input int fn, input logic [31:0] imm, input int tgt);
    in_kind   = 3'(k);
    in_opcode = 6'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_funct  = 6'(fn);
    in_imm    = imm;
    in_target = 26'(tgt);
  endtask

  task automatic rand_req();
    int k, m;
    logic [31:0] imm;
    k = $urandom_range(0, 7);
    m = $urandom_range(0, 3);
    imm = $urandom;
    if (m == 0) imm[31:16] = 16'h0000;
    else if (m == 1) imm[15:0] = 16'h0000;
    else if (m == 2 && $urandom_range(0, 3) == 0) imm = 32'h0;
    set_req(k, (k == 2 && $urandom_range(0, 2) != 0) ? $urandom_range(2, 3) : $urandom_range(0, 63),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 63), imm, $urandom_range(0, 67108863));
  endtask

  // Present the current request to dut_a (to_b=0) or dut_b (to_b=1) until accepted.
  task automatic send(input bit to_b);
    int cyc;
    @(posedge clock); #1;
    if (to_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    cyc = 0;
    @(negedge clock);
    while (!(to_b ? in_ready_b : in_ready_a) && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 50) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    if (to_b) in_valid_b = 1'b0; else in_valid_a = 1'b0;
  endtask

  // Scoreboard for dut_a: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    int n;
    logic [31:0] w0, w1;
    bit bad;
    if (reset) begin
      qa.delete();
      exp_err_a = 1'b0;
    end else begin
      exp_ready = (qa.size() == 0) || (qa.size() == 1 && out_ready_a);
      check_eq("sb_in_ready", in_ready_a, exp_ready);
      check_eq("sb_out_valid", out_valid_a, qa.size() != 0);
      if (out_valid_a && qa.size() != 0) begin
        check_eq("sb_word", out_instr_a, qa[0].w);
        check_eq("sb_last", out_last_a, qa[0].last);
      end
      check_eq("sb_err", err_a, exp_err_a);
      if (out_valid_a && out_ready_a && qa.size() != 0) void'(qa.pop_front());
      exp_err_a = 1'b0;
      if (in_valid_a && in_ready_a) begin
        model(1'b1, int'(in_kind), int'(in_opcode), int'(in_rs), int'(in_rt), int'(in_rd),
              int'(in_shamt), int'(in_funct), in_imm, int'(in_target), n, w0, w1, bad);
        if (n >= 1) qa.push_back('{w: w0, last: (n == 1)});
        if (n == 2) qa.push_back('{w: w1, last: 1'b1});
        exp_err_a = bad;
      end
    end
  end

  initial begin
    bit acc;
    int n;
    logic [31:0] w0, w1, imm;
    bit bad;
    n_checks    = 0;
    n_errors    = 0;
    exp_err_a   = 1'b0;
    in_valid_a  = 1'b0;
    in_valid_b  = 1'b0;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    reset = 1'b1;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_valid", out_valid_a, 1'b0);
    check_eq("rst_instr", out_instr_a, 32'h0);
    check_eq("rst_last", out_last_a, 1'b0);
    check_eq("rst_err", err_a, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready_a, 1'b1);

    // Basic encodings.
    set_req(0, 0, 8, 9, 10, 0, 33, 32'h0, 0);       send(1'b0);
    check_eq("enc_r", out_instr_a, 32'h0109_5021);
    check_eq("enc_r_last", out_last_a, 1'b1);
    set_req(4, 0, 5, 0, 2, 0, 0, 32'h0, 0);         send(1'b0);
    check_eq("enc_move", out_instr_a, 32'h0005_1021);
    set_req(6, 0, 3, 0, 0, 0, 0, 32'h0000_FFFE, 0); send(1'b0);
    check_eq("enc_bnez", out_instr_a, 32'h1403_FFFE);

    // Two-word li.
    set_req(3, 0, 0, 4, 0, 0, 0, 32'h1234_5678, 0); send(1'b0);
    check_eq("li_lui", out_instr_a, 32'h3C04_1234);
    check_eq("li_lui_last", out_last_a, 1'b0);
    check_eq("li_stall", in_ready_a, 1'b0);
    @(posedge clock); #1;
    check_eq("li_ori", out_instr_a, 32'h3484_5678);
    check_eq("li_ori_last", out_last_a, 1'b1);
    check_eq("li_ready_back", in_ready_a, 1'b1);

    // Single-word li shortcuts.
    set_req(3, 0, 0, 2, 0, 0, 0, 32'h0000_BEEF, 0); send(1'b0);
    check_eq("li_opt_ori", out_instr_a, 32'h3402_BEEF);
    check_eq("li_opt_ori_last", out_last_a, 1'b1);
    set_req(3, 0, 0, 2, 0, 0, 0, 32'hABCD_0000, 0); send(1'b0);
    check_eq("li_opt_lui", out_instr_a, 32'h3C02_ABCD);
    check_eq("li_opt_lui_last", out_last_a, 1'b1);

    // Backpressure on the first li word, then back-to-back R stream.
    @(posedge clock); #1;
    out_ready_a = 1'b0;
    set_req(3, 0, 0, 4, 0, 0, 0, 32'h1234_5678, 0); send(1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_hold", out_instr_a, 32'h3C04_1234);
      check_eq("bp_in_ready", in_ready_a, 1'b0);
      @(posedge clock); #1;
    end
    out_ready_a = 1'b1;
    @(posedge clock); #1;
    check_eq("bp_ori", out_instr_a, 32'h3484_5678);
    for (int i = 0; i < 4; i++) begin
      set_req(0, 0, i + 1, i + 2, i + 3, i, 32, 32'h0, 0);
      in_valid_a = 1'b1;
      @(posedge clock); #1;
      check_eq("b2b_valid", out_valid_a, 1'b1);
      check_eq("b2b_word", out_instr_a, rtype(i + 1, i + 2, i + 3, i, 32));
    end
    in_valid_a = 1'b0;

    // Illegal requests.
    set_req(7, 0, 1, 2, 3, 4, 5, 32'h0, 0);         send(1'b0);
    check_eq("ill_err", err_a, 1'b1);
    check_eq("ill_no_word", out_valid_a, 1'b0);
    @(posedge clock); #1;
    check_eq("ill_err_drop", err_a, 1'b0);
    set_req(2, 4, 0, 0, 0, 0, 0, 32'h0, 64);        send(1'b0);
    check_eq("ill_j_err", err_a, 1'b1);
    check_eq("ill_j_no_word", out_valid_a, 1'b0);
    set_req(2, 3, 0, 0, 0, 0, 0, 32'h0, 64);        send(1'b0);
    check_eq("enc_jal", out_instr_a, 32'h0C00_0040);
    check_eq("enc_jal_err", err_a, 1'b0);

    // Asynchronous reset while the ori is pending.
    @(posedge clock); #1;
    out_ready_a = 1'b0;
    set_req(3, 0, 0, 4, 0, 0, 0, 32'h1234_5678, 0); send(1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", out_valid_a, 1'b0);
    check_eq("arst_last", out_last_a, 1'b0);
    check_eq("arst_err", err_a, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("arst_in_ready", in_ready_a, 1'b1);
    out_ready_a = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check_eq("arst_no_ori", out_valid_a, 1'b0);
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      acc = in_valid_a && in_ready_a;
      @(posedge clock); #1;
      if (!in_valid_a || acc) begin
        rand_req();
        in_valid_a = ($urandom_range(0, 3) != 0);
      end
      out_ready_a = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    @(posedge clock); #1;
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_eq("drain_empty", out_valid_a, 1'b0);

    // LI_OPT=0 always emits lui then ori.
    set_req(3, 0, 0, 2, 0, 0, 0, 32'h0000_BEEF, 0); send(1'b1);
    check_eq("nopt_lui", out_instr_b, 32'h3C02_0000);
    check_eq("nopt_lui_last", out_last_b, 1'b0);
    check_eq("nopt_stall", in_ready_b, 1'b0);
    @(posedge clock); #1;
    check_eq("nopt_ori", out_instr_b, 32'h3442_BEEF);
    check_eq("nopt_ori_last", out_last_b, 1'b1);
    for (int i = 0; i < 8; i++) begin
      imm = $urandom;
      if (i % 3 == 0) imm[31:16] = 16'h0000;
      if (i % 3 == 1) imm[15:0] = 16'h0000;
      set_req(3, 0, 0, $urandom_range(0, 31), 0, 0, 0, imm, 0);
      model(1'b0, 3, 0, 0, int'(in_rt), 0, 0, 0, imm, 0, n, w0, w1, bad);
      send(1'b1);
      check_eq("nopt_rand_w0", out_instr_b, w0);
      @(posedge clock); #1;
      check_eq("nopt_rand_w1", out_instr_b, w1);
      check_eq("nopt_rand_err", err_b, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Stream-side instruction encoder and pseudo-instruction expander for the pipelined MIPS core; it is the inverse of opcode classification in decode.
- Accepts one field-level instruction request per handshake and emits 32-bit machine words on a valid/ready output stream.
- Pseudo-instructions (li, move, b, bnez) are expanded into real R/I-type words, with li producing up to two words.
- Feeds the instruction-memory loader and the self-check testbenches.

Parameters:
LI_OPT, 1, when 1 li emits a single word if either immediate half is zero; when 0 li always emits lui+ori

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  request present
in_ready  output  1  request accepted on posedge when in_valid&in_ready
in_kind  input  3  0=R 1=I 2=J 3=LI 4=MOVE 5=B 6=BNEZ 7=illegal
in_opcode  input  6  opcode for I and J kinds; ignored otherwise
in_rs  input  5  rs field; source register for MOVE and BNEZ
in_rt  input  5  rt field; destination register for LI
in_rd  input  5  rd field; destination register for MOVE
in_shamt  input  5  shamt for R kind
in_funct  input  6  funct for R kind
in_imm  input  32  immediate; LI uses all 32 bits, I/B/BNEZ use [15:0]
in_target  input  26  J-kind target
out_valid  output  1  out_instr holds a word
out_ready  input  1  consumer takes the word on posedge when out_valid&out_ready
out_instr  output  32  encoded word
out_last  output  1  word is the final word of its request
err  output  1  one-cycle pulse: an accepted request was illegal

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_last=0, err=0, state=IDLE, pending word=0.
- Reset mid-expansion discards the pending ori.
- States:
  - IDLE: normal acceptance.
  - SECOND: the second li word is pending.
- in_ready = (state==IDLE) & (~out_valid | out_ready). in_ready is combinational from out_ready; no other comb in->out paths.
- Latency: a request accepted at posedge N has its first word with out_valid=1 after posedge N. With out_ready held high, throughput is 1 word/cycle.
- Output register update:
  - On a handoff (out_valid&out_ready) with no new load, out_valid drops to 0.
  - While out_valid&~out_ready, out_instr and out_last are held stable.
- Encodings:
  - R: {6'h00, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, imm[15:0]}.
  - J: {opcode, target}. opcode must be 6'h02 or 6'h03; any other value is illegal.
  - MOVE: addu rd,$zero,rs = {6'h00, 5'd0, rs, rd, 5'd0, 6'h21}.
  - B: beq $zero,$zero = {6'h04, 5'd0, 5'd0, imm[15:0]}.
  - BNEZ: bne $zero,rs = {6'h05, 5'd0, rs, imm[15:0]}.
- LI (hi=imm[31:16], lo=imm[15:0], rt=dest):
  - LI_OPT=1 and hi==0: single ori rt,$zero,lo = {6'h0D, 5'd0, rt, lo}, out_last=1. Also covers imm==0.
  - LI_OPT=1 and lo==0 (hi!=0): single lui = {6'h0F, 5'd0, rt, hi}, out_last=1.
  - Otherwise, two words:
    - First word lui, out_last=0; go to SECOND and latch pending = {6'h0D, rt, rt, lo}.
    - In SECOND, on handoff: load pending with out_last=1 and return to IDLE.
    - in_ready=0 for the whole of SECOND.
- Illegal request (kind 7, or J with a bad opcode): accepted normally. err=1 for exactly the next cycle; no word is produced and no state change occurs.
- err is registered; it is 0 in every other cycle.
- Simultaneous handoff and accept in IDLE: the new word replaces the old one in the same edge, so there is no bubble.

Test Plan:
- Encodings with out_ready=1:
  - R rs=8 rt=9 rd=10 shamt=0 funct=0x21 -> one cycle later out_instr=0x01095021, out_last=1.
  - MOVE rd=2 rs=5 -> 0x00051021.
  - BNEZ rs=3 imm=0xFFFE -> 0x1403FFFE.
- LI rt=4 imm=0x12345678, out_ready=1 -> 0x3C041234 (last=0), then 0x34845678 (last=1). in_ready=0 for one cycle, then 1.
- LI_OPT=1:
  - rt=2 imm=0x0000BEEF -> single 0x3402BEEF, last=1.
  - rt=2 imm=0xABCD0000 -> single 0x3C02ABCD.
  - LI_OPT=0 with imm=0x0000BEEF -> 0x3C020000 then 0x3442BEEF.
- Backpressure:
  - LI from the second test with out_ready=0 for 3 cycles after the first word -> out_instr holds 0x3C041234, in_ready=0.
  - Release -> ori emitted, then back-to-back R requests stream with no bubble.
- Illegal requests:
  - kind=7 -> err high exactly one cycle, out_valid stays 0.
  - kind=J opcode=0x04 -> err pulse.
  - kind=J opcode=0x03 target=0x0000040 -> 0x0C000040.
- Async reset asserted mid-cycle in SECOND -> out_valid, out_last and err drop immediately. After release, in_ready=1 and no pending ori is emitted.
